// File: rtl/pcs_sync_pkg.sv
// Shared types and code-group tables for the 1000BASE-X PCS receive synchronization block.
package pcs_sync_pkg;

  typedef enum logic [3:0] {
    StLossOfSync,
    StCommaDetect1,
    StAcquireSync1,
    StCommaDetect2,
    StAcquireSync2,
    StCommaDetect3,
    StSyncAcquired1,
    StSyncAcquired2,
    StSyncAcquired2A,
    StSyncAcquired3,
    StSyncAcquired3A,
    StSyncAcquired4,
    StSyncAcquired4A
  } state_e;

  localparam logic [6:0] CommaPos = 7'b0011111;
  localparam logic [6:0] CommaNeg = 7'b1100000;

  localparam int unsigned NumLegal6b = 48;
  localparam int unsigned NumLegal4b = 14;

  // abcdei sub-blocks: D.0..D.31 in both disparity columns, then K.28
  localparam logic [5:0] Legal6b [NumLegal6b] = '{
    6'b100111, 6'b011000, 6'b011101, 6'b100010, 6'b101101, 6'b010010, 6'b110001, 6'b110101,
    6'b001010, 6'b101001, 6'b011001, 6'b111000, 6'b000111, 6'b111001, 6'b000110, 6'b100101,
    6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b101000, 6'b011011,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b000101, 6'b110011, 6'b001100, 6'b100110, 6'b010110, 6'b110110, 6'b001001, 6'b001110,
    6'b101110, 6'b010001, 6'b011110, 6'b100001, 6'b101011, 6'b010100, 6'b001111, 6'b110000
  };

  // fghj sub-blocks, including the alternate x.7 encodings
  localparam logic [3:0] Legal4b [NumLegal4b] = '{
    4'b1011, 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b0011, 4'b1101,
    4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0001, 4'b0111, 4'b1000
  };

  localparam logic [9:0] K28_5 = 10'b0011111010;
  localparam logic [9:0] D3_0  = 10'b1100011011;
  localparam logic [9:0] D4_0  = 10'b1101010100;
  localparam logic [9:0] D5_0  = 10'b1010011011;
  localparam logic [9:0] D6_0  = 10'b0110011011;
  localparam logic [9:0] D7_0  = 10'b1110001011;
  localparam logic [9:0] D8_0  = 10'b1110010100;

  function automatic logic is_sync_state(state_e s);
    return (s == StSyncAcquired1)  || (s == StSyncAcquired2)  || (s == StSyncAcquired2A) ||
           (s == StSyncAcquired3)  || (s == StSyncAcquired3A) || (s == StSyncAcquired4)  ||
           (s == StSyncAcquired4A);
  endfunction

endpackage

// File: rtl/pcs_synchronization_cg_classifier.sv
// Combinational comma / code-group validity detector (running disparity ignored).
module cg_classifier
  import pcs_sync_pkg::*;
(
  input  logic [9:0] rx_code_group,
  output logic       comma,
  output logic       valid
);

  logic valid6;
  logic valid4;

  assign comma = (rx_code_group[9:3] == CommaPos) || (rx_code_group[9:3] == CommaNeg);

  always_comb begin
    valid6 = 1'b0;
    valid4 = 1'b0;
    for (int i = 0; i < NumLegal6b; i++) begin
      if (rx_code_group[9:4] == Legal6b[i]) valid6 = 1'b1;
    end
    for (int i = 0; i < NumLegal4b; i++) begin
      if (rx_code_group[3:0] == Legal4b[i]) valid4 = 1'b1;
    end
  end

  assign valid = valid6 && valid4;

endmodule

// File: rtl/pcs_synchronization.sv
// 1000BASE-X PCS receive synchronization: comma alignment, even/odd tracking and sync_status.
module pcs_synchronization
  import pcs_sync_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       PUDI,
  input  logic [9:0] rx_code_group,
  output logic [9:0] x,
  output logic       rx_even,
  output logic       sync_status,
  output logic       SUDI
);

  state_e     state_q, state_d;
  logic [1:0] good_cgs_q, good_cgs_d;
  logic [9:0] x_q, x_d;
  logic       rx_even_q, rx_even_d;
  logic       sync_q, sync_d;
  logic       sudi_q;

  logic comma;
  logic valid;
  logic cgbad;
  logic cggood;
  logic data;

  cg_classifier u_classifier (
    .rx_code_group(rx_code_group),
    .comma        (comma),
    .valid        (valid)
  );

  // A comma is only legal in an even position, i.e. when the previous group was odd
  assign cgbad  = !valid || (comma && rx_even_q);
  assign cggood = !cgbad;
  assign data   = valid && !comma;

  always_comb begin
    state_d    = state_q;
    good_cgs_d = good_cgs_q;
    x_d        = x_q;
    rx_even_d  = rx_even_q;
    if (PUDI) begin
      x_d = rx_code_group;
      unique case (state_q)
        StLossOfSync:   if (comma) state_d = StCommaDetect1;
        StCommaDetect1: state_d = data ? StAcquireSync1 : StLossOfSync;
        StAcquireSync1: begin
          if (cgbad) state_d = StLossOfSync;
          else if (comma && !rx_even_q) state_d = StCommaDetect2;
        end
        StCommaDetect2: state_d = data ? StAcquireSync2 : StLossOfSync;
        StAcquireSync2: begin
          if (cgbad) state_d = StLossOfSync;
          else if (comma && !rx_even_q) state_d = StCommaDetect3;
        end
        StCommaDetect3:  state_d = data ? StSyncAcquired1 : StLossOfSync;
        StSyncAcquired1: if (cgbad) state_d = StSyncAcquired2;
        StSyncAcquired2, StSyncAcquired3, StSyncAcquired4: begin
          if (cggood) begin
            good_cgs_d = 2'd1;
            state_d    = (state_q == StSyncAcquired2) ? StSyncAcquired2A :
                         (state_q == StSyncAcquired3) ? StSyncAcquired3A : StSyncAcquired4A;
          end else begin
            state_d = (state_q == StSyncAcquired2) ? StSyncAcquired3 :
                      (state_q == StSyncAcquired3) ? StSyncAcquired4 : StLossOfSync;
          end
        end
        StSyncAcquired2A, StSyncAcquired3A, StSyncAcquired4A: begin
          if (cgbad) begin
            good_cgs_d = 2'd0;
            state_d    = (state_q == StSyncAcquired2A) ? StSyncAcquired3 :
                         (state_q == StSyncAcquired3A) ? StSyncAcquired4 : StLossOfSync;
          end else if (good_cgs_q == 2'd3) begin
            good_cgs_d = 2'd0;
            state_d    = (state_q == StSyncAcquired2A) ? StSyncAcquired1 :
                         (state_q == StSyncAcquired3A) ? StSyncAcquired2 : StSyncAcquired3;
          end else begin
            good_cgs_d = good_cgs_q + 2'd1;
          end
        end
        default: state_d = StLossOfSync;
      endcase
      rx_even_d = ((state_d == StCommaDetect1) || (state_d == StCommaDetect2) ||
                   (state_d == StCommaDetect3)) ? 1'b1 : !rx_even_q;
    end
    sync_d = is_sync_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLossOfSync;
      good_cgs_q <= 2'd0;
      x_q        <= 10'd0;
      rx_even_q  <= 1'b0;
      sync_q     <= 1'b0;
      sudi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cgs_q <= good_cgs_d;
      x_q        <= x_d;
      rx_even_q  <= rx_even_d;
      sync_q     <= sync_d;
      sudi_q     <= PUDI;
    end
  end

  assign x           = x_q;
  assign rx_even     = rx_even_q;
  assign sync_status = sync_q;
  assign SUDI        = sudi_q;

endmodule

// File: tb/tb_pcs_synchronization.sv
// Directed, table-driven bench for pcs_synchronization.
module tb_pcs_synchronization;
  import pcs_sync_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PUDI = 1'b0;
  logic [9:0] rx_code_group = 10'd0;
  logic [9:0] x;
  logic       rx_even;
  logic       sync_status;
  logic       SUDI;

  int checks = 0;
  int fails  = 0;

  localparam logic [9:0] Bad = 10'b0000010110;

  pcs_synchronization dut (
    .clk          (clk),
    .rst          (rst),
    .PUDI         (PUDI),
    .rx_code_group(rx_code_group),
    .x            (x),
    .rx_even      (rx_even),
    .sync_status  (sync_status),
    .SUDI         (SUDI)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       pudi;
    logic [9:0] cg;
    logic [9:0] ex;
    logic       even;
    logic       sync;
    logic       sudi;
    state_e     st;
    logic [1:0] gcs;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    PUDI          = v.pudi;
    rx_code_group = v.cg;
    @(posedge clk);
    #1;
    chk("x", idx, 32'(x), 32'(v.ex));
    chk("rx_even", idx, 32'(rx_even), 32'(v.even));
    chk("sync_status", idx, 32'(sync_status), 32'(v.sync));
    chk("SUDI", idx, 32'(SUDI), 32'(v.sudi));
    chk("state", idx, 32'(dut.state_q), 32'(v.st));
    chk("good_cgs", idx, 32'(dut.good_cgs_q), 32'(v.gcs));
  endtask

  initial begin
    vec_t v;
    // rst pudi cg | x even sync sudi state gcs
    vecs[0]  = '{1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, StLossOfSync, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect1, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, D5_0, D5_0, 1'b0, 1'b0, 1'b1, StAcquireSync1, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect2, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, D8_0, D8_0, 1'b0, 1'b0, 1'b1, StAcquireSync2, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect3, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, D3_0, D3_0, 1'b0, 1'b1, 1'b1, StSyncAcquired1, 2'd0};
    // single error then four good groups back to SA1
    vecs[7]  = '{1'b0, 1'b1, Bad, Bad, 1'b1, 1'b1, 1'b1, StSyncAcquired2, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, D4_0, D4_0, 1'b0, 1'b1, 1'b1, StSyncAcquired2A, 2'd1};
    vecs[9]  = '{1'b0, 1'b1, D5_0, D5_0, 1'b1, 1'b1, 1'b1, StSyncAcquired2A, 2'd2};
    vecs[10] = '{1'b0, 1'b1, D6_0, D6_0, 1'b0, 1'b1, 1'b1, StSyncAcquired2A, 2'd3};
    vecs[11] = '{1'b0, 1'b1, D7_0, D7_0, 1'b1, 1'b1, 1'b1, StSyncAcquired1, 2'd0};
    // comma in odd position counts as bad, then erode to loss of sync
    vecs[12] = '{1'b0, 1'b1, K28_5, K28_5, 1'b0, 1'b1, 1'b1, StSyncAcquired2, 2'd0};
    vecs[13] = '{1'b0, 1'b1, D4_0, D4_0, 1'b1, 1'b1, 1'b1, StSyncAcquired2A, 2'd1};
    vecs[14] = '{1'b0, 1'b1, Bad, Bad, 1'b0, 1'b1, 1'b1, StSyncAcquired3, 2'd0};
    vecs[15] = '{1'b0, 1'b1, D5_0, D5_0, 1'b1, 1'b1, 1'b1, StSyncAcquired3A, 2'd1};
    vecs[16] = '{1'b0, 1'b1, Bad, Bad, 1'b0, 1'b1, 1'b1, StSyncAcquired4, 2'd0};
    vecs[17] = '{1'b0, 1'b1, Bad, Bad, 1'b1, 1'b0, 1'b1, StLossOfSync, 2'd0};
    vecs[18] = '{1'b0, 1'b0, D3_0, Bad, 1'b1, 1'b0, 1'b0, StLossOfSync, 2'd0};
    // second comma while in CD1 aborts acquisition
    vecs[19] = '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect1, 2'd0};
    vecs[20] = '{1'b0, 1'b1, K28_5, K28_5, 1'b0, 1'b0, 1'b1, StLossOfSync, 2'd0};
    vecs[21] = '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect1, 2'd0};
    vecs[22] = '{1'b0, 1'b1, D5_0, D5_0, 1'b0, 1'b0, 1'b1, StAcquireSync1, 2'd0};

    for (int i = 0; i < 23; i++) apply(i, vecs[i]);

    // PUDI idle mid-acquisition: everything frozen, SUDI low
    for (int i = 0; i < 5; i++) begin
      v = '{1'b0, 1'b0, 10'($urandom), D5_0, 1'b0, 1'b0, 1'b0, StAcquireSync1, 2'd0};
      apply(100 + i, v);
    end

    apply(200, '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect2, 2'd0});
    apply(201, '{1'b0, 1'b1, D8_0, D8_0, 1'b0, 1'b0, 1'b1, StAcquireSync2, 2'd0});
    apply(202, '{1'b0, 1'b1, K28_5, K28_5, 1'b1, 1'b0, 1'b1, StCommaDetect3, 2'd0});
    apply(203, '{1'b0, 1'b1, D3_0, D3_0, 1'b0, 1'b1, 1'b1, StSyncAcquired1, 2'd0});
    // reset wins over a simultaneous strobe
    apply(204, '{1'b1, 1'b1, K28_5, 10'd0, 1'b0, 1'b0, 1'b0, StLossOfSync, 2'd0});
    apply(205, '{1'b0, 1'b1, D3_0, D3_0, 1'b1, 1'b0, 1'b1, StLossOfSync, 2'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pcs_synchronization.md
Name: pcs_synchronization

Overview:
- 1000BASE-X PCS receive synchronization block, following the IEEE 802.3 Clause 36 synchronization state diagram.
- Consumes one 10-bit code group per PUDI strobe and detects commas and invalid code groups.
- Tracks even/odd code-group alignment and asserts sync_status once three comma+data pairs have been received cleanly.
- Forwards each code group (x, SUDI, rx_even) to the downstream receive state machine.

Parameters:
- None. All constants live in the shared package.

Ports:
- clk  in  1  System clock; all logic rises on posedge.
- rst  in  1  Reset. Synchronous, active-high.
- PUDI  in  1  Code-group strobe. rx_code_group is consumed only on cycles where PUDI=1.
- rx_code_group  in  10  Received code group. Bit 9 = a, bit 0 = j (abcdei fghj order).
- x  out  10  Registered copy of the last consumed code group.
- rx_even  out  1  Parity of the group in x: 1 = even, 0 = odd.
- sync_status  out  1  1 = OK (in a SYNC_ACQUIRED_* state), 0 = FAIL.
- SUDI  out  1  Registered PUDI; 1-cycle strobe that qualifies x and rx_even.

Behaviour:
- Reset values:
  - state = LOSS_OF_SYNC
  - x = 0, rx_even = 0, sync_status = 0, SUDI = 0, good_cgs = 0
- Cycles with PUDI=0:
  - State, rx_even, good_cgs and x hold.
  - SUDI <= 0.
- Cycles with PUDI=1:
  - x <= rx_code_group.
  - SUDI <= 1.
  - FSM advances. Latency is one clock.
- Classification:
  - comma = bits[9:3] == 7'b0011111 or 7'b1100000.
  - valid = the 6b sub-block is in the 5b/6b table (either disparity column, plus K28 001111/110000), AND the 4b sub-block is in the 3b/4b table (including the alternate x.7 codes).
  - Running disparity is not checked.
  - cgbad = !valid, or (comma and rx_even==1).
  - cggood = !cgbad.
  - data = valid and !comma.
- rx_even update on each consumed group:
  - Set to 1 on entering COMMA_DETECT_n.
  - Otherwise toggles.
- FSM transitions (evaluated only when PUDI=1):
  - LOSS_OF_SYNC: comma -> CD1; else stay.
  - CD1: data -> AS1; else LOSS_OF_SYNC.
  - AS1:
    - cgbad -> LOSS_OF_SYNC.
    - comma with rx_even==0 -> CD2.
    - else stay.
  - CD2: data -> AS2; else LOSS_OF_SYNC.
  - AS2: same rules as AS1, except the comma goes to CD3.
  - CD3: data -> SA1; else LOSS_OF_SYNC.
  - SA1: cgbad -> SA2; else stay.
  - SA2 / SA3 / SA4: cggood -> the matching nA state with good_cgs=1; cgbad -> next lower-sync state (SA2->SA3, SA3->SA4, SA4->LOSS_OF_SYNC).
  - SAnA (n = 2, 3, 4):
    - cgbad -> next lower state (SA2A->SA3, SA3A->SA4, SA4A->LOSS_OF_SYNC), good_cgs=0.
    - cggood and good_cgs==3 -> the previous higher state (SA2A->SA1, SA3A->SA2, SA4A->SA3), good_cgs=0.
    - otherwise good_cgs++ and stay.
- sync_status:
  - Registered.
  - 1 on the edge that enters SA1; stays 1 through all SA* states.
  - 0 on the edge that enters LOSS_OF_SYNC.
- good_cgs: 2-bit counter; never wraps, because it is cleared at 3.
- rst has priority over PUDI. Reset mid-sync drops sync_status the next cycle.

Decomposition:
- Package pcs_sync_pkg holds:
  - state enum (13 states)
  - comma patterns
  - legal 6b and 4b sub-block constants
  - K28_5 / Dx_y named code groups
- One sub-module, cg_classifier: combinational; rx_code_group -> comma, valid.

Test Plan:
- Reset, then one PUDI each of K28.5 10'b0011111010, D5.0, K28.5, D8.0, K28.5, D3.0 -> sync_status=1 the cycle after D3.0. rx_even alternates 1,0 on each K/D pair.
- After sync, send invalid 10'b0000010110 -> state SA2, sync_status stays 1. Then D4.0, D5.0, D6.0 (good_cgs 1..3), then D7.0 -> back in SA1.
- After sync, send four invalid groups interleaved with fewer than four good groups -> reaches LOSS_OF_SYNC, sync_status=0.
- K28.5 then a second K28.5 (odd position) while in CD1 -> LOSS_OF_SYNC, no sync.
- Hold PUDI=0 for 5 cycles mid-acquisition -> state, x and rx_even frozen; SUDI=0 throughout.
- Assert rst while synced -> the next cycle has sync_status=0, x=0, SUDI=0, rx_even=0.
